// File: rtl/accumulator_if.sv
// accumulator_if
//   Bundles the control/data handshake of the running-sum accumulator.
//   master : drives i_ENABLE, i_CLEAR, i_DATA_IN; observes o_TOTAL, o_OVERFLOW
//   slave  : the accumulator side (consumes inputs, drives the registered outputs)
//   DATA_W : width of the addend and the running total
interface accumulator_if #(
  parameter int DATA_W = 32
);
  logic              i_ENABLE;
  logic              i_CLEAR;
  logic [DATA_W-1:0] i_DATA_IN;
  logic [DATA_W-1:0] o_TOTAL;
  logic              o_OVERFLOW;

  modport master (
    output i_ENABLE,
    output i_CLEAR,
    output i_DATA_IN,
    input  o_TOTAL,
    input  o_OVERFLOW
  );

  modport slave (
    input  i_ENABLE,
    input  i_CLEAR,
    input  i_DATA_IN,
    output o_TOTAL,
    output o_OVERFLOW
  );
endinterface

// File: rtl/accumulator.sv
// accumulator
//   Registered running-sum accumulator with optional saturation and a sticky
//   overflow flag.
//   Ports:
//     i_CLK      : single clock, all state updates on the rising edge
//     i_RESET_N  : asynchronous active-low reset (total and flag forced to 0)
//     bus        : accumulator_if.slave
//                  i_ENABLE  - add i_DATA_IN this edge (else hold)
//                  i_CLEAR   - synchronous clear, wins over i_ENABLE
//                  i_DATA_IN - unsigned addend
//                  o_TOTAL   - registered running sum
//                  o_OVERFLOW- sticky carry-out flag
//   Parameters:
//     DATA_W   : data/total width
//     SATURATE : 0 wraps modulo 2**DATA_W, 1 clamps at all-ones
module accumulator #(
  parameter int DATA_W   = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic         i_CLK,
  input  logic         i_RESET_N,
  accumulator_if.slave bus
);

  logic [DATA_W-1:0] total_q, total_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W:0]   sum;
  logic              carry;

  // One extra bit on the adder exposes the carry-out directly.
  assign sum   = {1'b0, total_q} + {1'b0, bus.i_DATA_IN};
  assign carry = sum[DATA_W];

  always_comb begin
    total_d    = total_q;
    overflow_d = overflow_q;
    if (bus.i_CLEAR) begin
      total_d    = '0;
      overflow_d = 1'b0;
    end else if (bus.i_ENABLE) begin
      if (SATURATE && carry) begin
        total_d = '1;
      end else begin
        total_d = sum[DATA_W-1:0];
      end
      overflow_d = overflow_q | carry;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.o_TOTAL    = total_q;
  assign bus.o_OVERFLOW = overflow_q;

endmodule

// File: tb/tb_accumulator.sv
// tb_accumulator
//   Directed bench driving a wrapping (SATURATE=0) and a saturating
//   (SATURATE=1) accumulator with identical stimulus; each vector carries
//   hand-computed expectations for both instances.
module tb_accumulator;

  logic i_CLK;
  logic i_RESET_N;

  int checks;
  int errors;

  accumulator_if #(.DATA_W(32)) bus_wrap ();
  accumulator_if #(.DATA_W(32)) bus_sat ();

  accumulator #(.DATA_W(32), .SATURATE(1'b0)) u_wrap (
    .i_CLK     (i_CLK),
    .i_RESET_N (i_RESET_N),
    .bus       (bus_wrap.slave)
  );

  accumulator #(.DATA_W(32), .SATURATE(1'b1)) u_sat (
    .i_CLK     (i_CLK),
    .i_RESET_N (i_RESET_N),
    .bus       (bus_sat.slave)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic [31:0] data);
    bus_wrap.i_ENABLE  = en;
    bus_wrap.i_CLEAR   = clr;
    bus_wrap.i_DATA_IN = data;
    bus_sat.i_ENABLE   = en;
    bus_sat.i_CLEAR    = clr;
    bus_sat.i_DATA_IN  = data;
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] tot_w, input logic ov_w,
                           input logic [31:0] tot_s, input logic ov_s);
    check({tag, ".wrap.total"}, bus_wrap.o_TOTAL, tot_w);
    check({tag, ".wrap.ovf"}, {31'd0, bus_wrap.o_OVERFLOW}, {31'd0, ov_w});
    check({tag, ".sat.total"}, bus_sat.o_TOTAL, tot_s);
    check({tag, ".sat.ovf"}, {31'd0, bus_sat.o_OVERFLOW}, {31'd0, ov_s});
  endtask

  // Apply one vector, clock it in, then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic en, input logic clr, input logic [31:0] data,
                      input logic [31:0] tot_w, input logic ov_w,
                      input logic [31:0] tot_s, input logic ov_s);
    drive(en, clr, data);
    @(posedge i_CLK);
    #1;
    check_all(tag, tot_w, ov_w, tot_s, ov_s);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    i_RESET_N = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge i_CLK);
    #1;
    check_all("reset", 32'd0, 1'b0, 32'd0, 1'b0);
    i_RESET_N = 1'b1;

    step("add100", 1'b1, 1'b0, 32'd100, 32'd100, 1'b0, 32'd100, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 1'b0, 32'h4000_0000, 32'd100, 1'b0, 32'd100, 1'b0);

    // Asynchronous reset between edges with enable active.
    drive(1'b1, 1'b0, 32'd7);
    #3;
    i_RESET_N = 1'b0;
    #1;
    check_all("async_rst", 32'd0, 1'b0, 32'd0, 1'b0);
    @(posedge i_CLK);
    #1;
    check_all("rst_held", 32'd0, 1'b0, 32'd0, 1'b0);
    i_RESET_N = 1'b1;

    step("add0", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step("to_max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
    step("max_plus2", 1'b1, 1'b0, 32'd2, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step("sticky", 1'b1, 1'b0, 32'd5, 32'd6, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step("hold_ovf", 1'b0, 1'b0, 32'd9, 32'd6, 1'b1, 32'hFFFF_FFFF, 1'b1);

    step("clr_prio", 1'b1, 1'b1, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0);
    step("after_clr", 1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 32'd5, 1'b0);

    step("to_fff0", 1'b1, 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFF0, 1'b0, 32'hFFFF_FFF0, 1'b0);
    step("add20", 1'b1, 1'b0, 32'h20, 32'h10, 1'b1, 32'hFFFF_FFFF, 1'b1);

    step("clr2", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step("max_again", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
    step("wrap_to0", 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step("add_after", 1'b1, 1'b0, 32'd3, 32'd3, 1'b1, 32'hFFFF_FFFF, 1'b1);

    // Reset after overflow discards both total and flag.
    drive(1'b1, 1'b0, 32'd1);
    #2;
    i_RESET_N = 1'b0;
    #1;
    check_all("rst_ovf", 32'd0, 1'b0, 32'd0, 1'b0);
    @(posedge i_CLK);
    #1;
    i_RESET_N = 1'b1;
    step("post_rst", 1'b1, 1'b0, 32'd42, 32'd42, 1'b0, 32'd42, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
